// File: rtl/vga_palette_ctrl.sv
// vga_palette_ctrl: buffers CPU palette writes in a FIFO and drains them into
// the palette write port. Draining is immediate, or in sync mode it happens
// only during vertical blanking, so that palette updates never tear mid-frame.
module vga_palette_ctrl #(
  parameter int DEPTH = 16,
  parameter int LW    = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_write,
  input  logic [9:0]    cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_ready,
  input  logic          ctrl_write,
  input  logic [1:0]    ctrl_wdata,
  input  logic          vblank,
  output logic          pal_write,
  output logic [9:0]    pal_addr,
  output logic [31:0]   pal_wdata,
  output logic [LW-1:0] fifo_level,
  output logic          drain_done
);

  localparam int AW = $clog2(DEPTH);

  logic [41:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] count;
  logic          sync_mode;

  logic flush;
  logic drain_en;
  logic enq;
  logic deq;

  // Handshake and scheduling decisions; a flush suppresses both queue operations.
  always_comb begin
    cpu_ready = (count != LW'(DEPTH));
    flush     = ctrl_write && ctrl_wdata[1];
    drain_en  = sync_mode ? vblank : 1'b1;
    enq       = cpu_write && cpu_ready && !flush;
    deq       = drain_en && (count != '0) && !flush;
  end

  assign fifo_level = count;

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (enq) mem[wptr] <= {cpu_addr, cpu_wdata};
  end

  // Pointers, level, control register and registered palette port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      sync_mode  <= 1'b0;
      pal_write  <= 1'b0;
      pal_addr   <= '0;
      pal_wdata  <= '0;
      drain_done <= 1'b0;
    end else begin
      if (ctrl_write) sync_mode <= ctrl_wdata[0];

      if (flush) begin
        rptr  <= wptr;
        count <= '0;
      end else begin
        if (enq) wptr <= wptr + AW'(1);
        if (deq) rptr <= rptr + AW'(1);
        if (enq && !deq)      count <= count + LW'(1);
        else if (deq && !enq) count <= count - LW'(1);
      end

      pal_write  <= deq;
      drain_done <= deq && !enq && (count == LW'(1));
      if (deq) begin
        pal_addr  <= mem[rptr][41:32];
        pal_wdata <= mem[rptr][31:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_palette_ctrl.sv
// Self-checking bench for vga_palette_ctrl: a vector table for the basic
// immediate/sync sequences, then directed multi-cycle corner cases checked
// against an expected-write queue.
module tb_vga_palette_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_write = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic        ctrl_write = 1'b0;
  logic [1:0]  ctrl_wdata = '0;
  logic        vblank = 1'b0;
  logic        pal_write;
  logic [9:0]  pal_addr;
  logic [31:0] pal_wdata;
  logic [4:0]  fifo_level;
  logic        drain_done;

  vga_palette_ctrl #(.DEPTH(16), .LW(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .ctrl_write(ctrl_write), .ctrl_wdata(ctrl_wdata), .vblank(vblank),
    .pal_write(pal_write), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .fifo_level(fifo_level), .drain_done(drain_done)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        cw;
    logic [9:0]  ca;
    logic [31:0] cd;
    logic        kw;
    logic [1:0]  kd;
    logic        vb;
    logic        e_pw;
    logic [9:0]  e_pa;
    logic [31:0] e_pd;
    logic [4:0]  e_lv;
    logic        e_rdy;
    logic        e_dd;
  } vec_t;

  function automatic vec_t mk(logic cw, logic [9:0] ca, logic [31:0] cd, logic kw,
                              logic [1:0] kd, logic vb, logic e_pw, logic [9:0] e_pa,
                              logic [31:0] e_pd, logic [4:0] e_lv, logic e_rdy, logic e_dd);
    vec_t v;
    v.cw = cw; v.ca = ca; v.cd = cd; v.kw = kw; v.kd = kd; v.vb = vb;
    v.e_pw = e_pw; v.e_pa = e_pa; v.e_pd = e_pd; v.e_lv = e_lv;
    v.e_rdy = e_rdy; v.e_dd = e_dd;
    return v;
  endfunction

  // Expected palette writes for the directed sections.
  typedef struct { logic [9:0] a; logic [31:0] d; } pw_t;
  pw_t exp_q[$];
  bit  mon_en = 1'b0;
  int  pal_cnt = 0;
  int  dd_cnt = 0;
  bit  seen_bad = 1'b0;

  // Palette-port monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (mon_en && pal_write) begin
      pal_cnt++;
      if (pal_wdata == 32'h0000DEAD || pal_wdata == 32'h0000BEEF ||
          pal_wdata == 32'h00000777) seen_bad = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_pal_write", {pal_addr, pal_wdata}, 42'h0);
      end else begin
        pw_t e;
        e = exp_q.pop_front();
        chk("mon_pal_addr", pal_addr, e.a);
        chk("mon_pal_wdata", pal_wdata, e.d);
      end
    end
    if (mon_en && drain_done) dd_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t vecs[$];

  initial begin
    int base_p;
    int base_d;
    int n;

    // Immediate mode: two writes drain back to back.
    vecs.push_back(mk(1, 10'h004, 32'h00FF8040, 0, 2'b00, 0, 0, 10'h000, 32'h0,        5'd1, 1, 0));
    vecs.push_back(mk(1, 10'h3FC, 32'h00123456, 0, 2'b00, 0, 1, 10'h004, 32'h00FF8040, 5'd1, 1, 0));
    vecs.push_back(mk(0, 10'h000, 32'h0,        0, 2'b00, 0, 1, 10'h3FC, 32'h00123456, 5'd0, 1, 1));
    vecs.push_back(mk(0, 10'h000, 32'h0,        0, 2'b00, 0, 0, 10'h3FC, 32'h00123456, 5'd0, 1, 0));
    // Enter sync mode; five writes wait for vblank.
    vecs.push_back(mk(0, 10'h000, 32'h0,        1, 2'b01, 0, 0, 10'h3FC, 32'h00123456, 5'd0, 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 10'(10'h041 + 4*i), 32'hA5000000 | 32'(i), 0, 2'b00, 0,
                        0, 10'h3FC, 32'h00123456, 5'(i + 1), 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 10'h000, 32'h0, 0, 2'b00, 1,
                        1, 10'(10'h041 + 4*i), 32'hA5000000 | 32'(i), 5'(4 - i), 1, (i == 4)));
    vecs.push_back(mk(0, 10'h000, 32'h0, 0, 2'b00, 1, 0, 10'h051, 32'hA5000004, 5'd0, 1, 0));

    // Reset state.
    #3;
    chk("rst_pal_write", pal_write, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", cpu_ready, 1);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_pal_addr", pal_addr, 0);
    chk("rst_pal_wdata", pal_wdata, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (vecs[k]) begin
      cpu_write = vecs[k].cw; cpu_addr = vecs[k].ca; cpu_wdata = vecs[k].cd;
      ctrl_write = vecs[k].kw; ctrl_wdata = vecs[k].kd; vblank = vecs[k].vb;
      step();
      chk($sformatf("v%0d_pal_write", k), pal_write, vecs[k].e_pw);
      chk($sformatf("v%0d_pal_addr", k), pal_addr, vecs[k].e_pa);
      chk($sformatf("v%0d_pal_wdata", k), pal_wdata, vecs[k].e_pd);
      chk($sformatf("v%0d_level", k), fifo_level, vecs[k].e_lv);
      chk($sformatf("v%0d_ready", k), cpu_ready, vecs[k].e_rdy);
      chk($sformatf("v%0d_drain_done", k), drain_done, vecs[k].e_dd);
    end
    cpu_write = 0; ctrl_write = 0; vblank = 0;
    mon_en = 1'b1;

    // Full FIFO in sync mode; writes while full are dropped.
    base_p = pal_cnt; base_d = dd_cnt;
    for (int i = 0; i < 16; i++) begin
      cpu_write = 1; cpu_addr = 10'(i*4 + 3); cpu_wdata = 32'h00000200 + 32'(i);
      exp_q.push_back('{a: 10'(i*4 + 3), d: 32'h00000200 + 32'(i)});
      step();
    end
    cpu_write = 0;
    chk("full_level", fifo_level, 16);
    chk("full_ready", cpu_ready, 0);
    cpu_write = 1; cpu_addr = 10'h3FF; cpu_wdata = 32'h0000DEAD;
    step();
    cpu_write = 0;
    chk("full_drop_level", fifo_level, 16);
    vblank = 1; cpu_write = 1; cpu_wdata = 32'h0000BEEF;
    step();
    cpu_write = 0;
    chk("full_deq_no_enq_level", fifo_level, 15);
    step(); step();
    vblank = 0;
    chk("partial_level", fifo_level, 13);
    step(); step();
    chk("partial_writes", pal_cnt - base_p, 3);
    chk("partial_level_hold", fifo_level, 13);
    vblank = 1;
    n = 0;
    while (fifo_level != 0 && n < 40) begin step(); n++; end
    vblank = 0;
    chk("full_drain_timeout", (n < 40), 1);
    step();
    chk("full_total_writes", pal_cnt - base_p, 16);
    chk("full_expq_empty", exp_q.size(), 0);
    chk("full_drain_done", dd_cnt - base_d, 1);
    chk("dropped_never_seen", seen_bad, 0);

    // Immediate mode, a write every cycle for 40 cycles.
    ctrl_write = 1; ctrl_wdata = 2'b00;
    step();
    ctrl_write = 0;
    base_p = pal_cnt;
    for (int i = 0; i < 40; i++) begin
      cpu_write = 1; cpu_addr = 10'(i*4 + 2); cpu_wdata = 32'h7E000300 + 32'(i);
      exp_q.push_back('{a: 10'(i*4 + 2), d: 32'h7E000300 + 32'(i)});
      step();
      chk("conc_level_le1", (fifo_level <= 1), 1);
    end
    cpu_write = 0;
    step(); step(); step();
    chk("conc_writes", pal_cnt - base_p, 40);
    chk("conc_expq_empty", exp_q.size(), 0);
    chk("conc_level_end", fifo_level, 0);

    // Flush with 7 queued in sync mode plus a simultaneous write.
    ctrl_write = 1; ctrl_wdata = 2'b01;
    step();
    ctrl_write = 0;
    base_p = pal_cnt; base_d = dd_cnt;
    for (int i = 0; i < 7; i++) begin
      cpu_write = 1; cpu_addr = 10'(i*4); cpu_wdata = 32'h00000500 + 32'(i);
      step();
    end
    chk("flush_pre_level", fifo_level, 7);
    cpu_write = 1; cpu_wdata = 32'h00000777; ctrl_write = 1; ctrl_wdata = 2'b11;
    step();
    cpu_write = 0; ctrl_write = 0;
    chk("flush_level", fifo_level, 0);
    chk("flush_ready", cpu_ready, 1);
    chk("flush_no_pal_write", pal_write, 0);
    vblank = 1;
    repeat (5) step();
    vblank = 0;
    chk("flush_vblank_no_writes", pal_cnt - base_p, 0);
    chk("flush_no_drain_done", dd_cnt - base_d, 0);
    chk("flush_level_after", fifo_level, 0);
    cpu_write = 1; cpu_addr = 10'h0AA; cpu_wdata = 32'h00000888;
    exp_q.push_back('{a: 10'h0AA, d: 32'h00000888});
    step();
    cpu_write = 0;
    chk("post_flush_level", fifo_level, 1);
    vblank = 1;
    step(); step();
    vblank = 0;
    chk("post_flush_writes", pal_cnt - base_p, 1);
    chk("post_flush_level0", fifo_level, 0);

    // Asynchronous reset in the middle of a drain.
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cpu_write = 1; cpu_addr = 10'(i*4 + 1); cpu_wdata = 32'h00000900 + 32'(i);
      step();
    end
    cpu_write = 0;
    vblank = 1;
    step();
    chk("rd_w0_pw", pal_write, 1);
    chk("rd_w0_pd", pal_wdata, 32'h00000900);
    step();
    chk("rd_w1_pw", pal_write, 1);
    chk("rd_w1_pd", pal_wdata, 32'h00000901);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rd_rst_pal_write", pal_write, 0);
    chk("rd_rst_level", fifo_level, 0);
    chk("rd_rst_ready", cpu_ready, 1);
    chk("rd_rst_pal_wdata", pal_wdata, 0);
    vblank = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cpu_write = 1; cpu_addr = 10'h155; cpu_wdata = 32'h00000999;
    step();
    cpu_write = 0;
    chk("rd_post_level", fifo_level, 1);
    step();
    chk("rd_post_immediate_pw", pal_write, 1);
    chk("rd_post_immediate_pd", pal_wdata, 32'h00000999);
    chk("rd_post_level0", fifo_level, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
